// File: rtl/sr_flag_arbiter_if.sv
//------------------------------------------------------------------------------
// sr_flag_arbiter_if : requester/flag-bank bus for sr_flag_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sr_flag_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
) ();
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NFLAG = 2 ** IDXW;

  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    req_sr;
  logic [IDXW*NREQ-1:0] req_idx;
  logic                 clr;
  logic [NREQ-1:0]      gnt;
  logic [NFLAG-1:0]     flags;
  logic                 err;
  logic [IDW-1:0]       err_id;
  logic                 busy;

  modport master (
    output req, req_sr, req_idx, clr,
    input  gnt, flags, err, err_id, busy
  );

  modport slave (
    input  req, req_sr, req_idx, clr,
    output gnt, flags, err, err_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/sr_flag_arbiter.sv
//------------------------------------------------------------------------------
// sr_flag_arbiter : round-robin arbitrated SR flag bank with clear sweep
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sr_flag_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
) (
  input  logic               clk,
  input  logic               rst,
  sr_flag_arbiter_if.slave   bus
);
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NFLAG = 2 ** IDXW;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NFLAG-1:0]  flags_q, flags_d;
  logic              err_q, err_d;
  logic [IDW-1:0]    err_id_q, err_id_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDXW-1:0]   sweep_q, sweep_d;

  logic [NREQ-1:0]   elig_w;
  logic              found_w;
  logic [IDW-1:0]    win_w;
  logic [1:0]        sr_w;
  logic [IDXW-1:0]   idx_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
      rr_q     <= '0;
      sweep_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
      rr_q     <= rr_d;
      sweep_q  <= sweep_d;
    end
  end

  // A requester whose grant is currently visible is masked for this edge.
  assign elig_w = bus.req & ~gnt_q;

  // Two passes: indices at/after the pointer first, then wrap to the bottom.
  always_comb begin
    found_w = 1'b0;
    win_w   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_w && elig_w[i] && (IDW'(i) >= rr_q)) begin
        found_w = 1'b1;
        win_w   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_w && elig_w[i]) begin
        found_w = 1'b1;
        win_w   = IDW'(i);
      end
    end
  end

  always_comb begin
    sr_w  = 2'b00;
    idx_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_w) begin
        sr_w  = bus.req_sr[2*i +: 2];
        idx_w = bus.req_idx[IDXW*i +: IDXW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    flags_d  = flags_q;
    err_d    = 1'b0;
    err_id_d = err_id_q;
    rr_d     = rr_q;
    sweep_d  = sweep_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr) begin
          state_d = S_SWEEP;
        end else if (found_w) begin
          gnt_d = NREQ'(1) << win_w;
          rr_d  = (win_w == IDW'(NREQ - 1)) ? '0 : win_w + 1'b1;
          case (sr_w)
            2'b01:   flags_d[idx_w] = 1'b0;
            2'b10:   flags_d[idx_w] = 1'b1;
            2'b11: begin
              err_d    = 1'b1;
              err_id_d = win_w;
            end
            default: ;
          endcase
        end
      end
      S_SWEEP: begin
        flags_d[sweep_q] = 1'b0;
        if (sweep_q == {IDXW{1'b1}}) begin
          state_d = S_IDLE;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.flags  = flags_q;
  assign bus.err    = err_q;
  assign bus.err_id = err_id_q;
  assign bus.busy   = (state_q == S_SWEEP);

endmodule

`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
//------------------------------------------------------------------------------
// tb_sr_flag_arbiter : directed self-checking bench for sr_flag_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sr_flag_arbiter;
  localparam int NREQ = 4;
  localparam int IDXW = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sr_flag_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();

  sr_flag_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [1:0] sr, input logic [IDXW-1:0] idx);
    bus.req_sr[2*i +: 2]        = sr;
    bus.req_idx[IDXW*i +: IDXW] = idx;
    bus.req[i]                  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0; bus.req_sr = '0; bus.req_idx = '0; bus.clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (bus.flags !== 8'h00) begin failures++; $display("FAIL reset_flags: got %h expected 00", bus.flags); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.err_id !== 2'd0) begin failures++; $display("FAIL reset_err_id: got %0d expected 0", bus.err_id); end
  endtask

  task automatic test_single();
    set_cmd(0, 2'b10, 3'd5);
    step();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_set_gnt: got %b expected 0001", bus.gnt); end
    checks++; if (bus.flags !== 8'h20) begin failures++; $display("FAIL single_set_flags: got %h expected 20", bus.flags); end
    set_cmd(0, 2'b01, 3'd5);
    step();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_masked_gnt: got %b expected 0000", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_clr_gnt: got %b expected 0001", bus.gnt); end
    checks++; if (bus.flags !== 8'h00) begin failures++; $display("FAIL single_clr_flags: got %h expected 00", bus.flags); end
    bus.req = '0;
    step();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_idle_gnt: got %b expected 0000", bus.gnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [7:0] exp_flags;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 2'b10, IDXW'(i));
    for (int k = 0; k < NREQ; k++) begin
      step();
      exp_gnt   = 4'b0001 << k;
      exp_flags = 8'((1 << (k + 1)) - 1);
      checks++; if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_gnt); end
      checks++; if (bus.flags !== exp_flags) begin failures++; $display("FAIL rr_flags[%0d]: got %h expected %h", k, bus.flags, exp_flags); end
      bus.req[k] = 1'b0;
    end
    step();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rr_done_gnt: got %b expected 0000", bus.gnt); end
  endtask

  task automatic test_mask();
    set_cmd(0, 2'b10, 3'd1);
    step();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL mask_c1: got %b expected 0001", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL mask_c2: got %b expected 0000", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL mask_c3: got %b expected 0001", bus.gnt); end
    bus.req = '0;
    step();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL mask_c4: got %b expected 0000", bus.gnt); end
    checks++; if (bus.flags !== 8'h0F) begin failures++; $display("FAIL mask_flags: got %h expected 0f", bus.flags); end
  endtask

  task automatic test_illegal();
    do_reset();
    set_cmd(3, 2'b10, 3'd3);
    step();
    bus.req = '0;
    step();
    checks++; if (bus.flags !== 8'h08) begin failures++; $display("FAIL ill_setup_flags: got %h expected 08", bus.flags); end
    set_cmd(2, 2'b11, 3'd3);
    step();
    bus.req = '0;
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL ill_gnt: got %b expected 0100", bus.gnt); end
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL ill_err: got %b expected 1", bus.err); end
    checks++; if (bus.err_id !== 2'd2) begin failures++; $display("FAIL ill_err_id: got %0d expected 2", bus.err_id); end
    checks++; if (bus.flags !== 8'h08) begin failures++; $display("FAIL ill_flags: got %h expected 08", bus.flags); end
    step();
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL ill_err_pulse: got %b expected 0", bus.err); end
    checks++; if (bus.err_id !== 2'd2) begin failures++; $display("FAIL ill_err_id_hold: got %0d expected 2", bus.err_id); end
  endtask

  task automatic test_conflict();
    do_reset();
    set_cmd(0, 2'b10, 3'd6);
    set_cmd(1, 2'b01, 3'd6);
    step();
    bus.req[0] = 1'b0;
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL conf_gnt0: got %b expected 0001", bus.gnt); end
    checks++; if (bus.flags !== 8'h40) begin failures++; $display("FAIL conf_flags0: got %h expected 40", bus.flags); end
    step();
    bus.req[1] = 1'b0;
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL conf_gnt1: got %b expected 0010", bus.gnt); end
    checks++; if (bus.flags !== 8'h00) begin failures++; $display("FAIL conf_flags1: got %h expected 00", bus.flags); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_flags;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_cmd(k % NREQ, 2'b10, IDXW'(k));
      step();
      bus.req = '0;
      step();
    end
    checks++; if (bus.flags !== 8'hFF) begin failures++; $display("FAIL sweep_setup: got %h expected ff", bus.flags); end
    bus.clr = 1'b1;
    set_cmd(1, 2'b10, 3'd0);
    step();
    bus.clr = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL sweep_start_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL sweep_clr_prio: got %b expected 0000", bus.gnt); end
    checks++; if (bus.flags !== 8'hFF) begin failures++; $display("FAIL sweep_start_flags: got %h expected ff", bus.flags); end
    for (int k = 0; k < 8; k++) begin
      if (k == 3) bus.clr = 1'b1;
      if (k == 4) bus.clr = 1'b0;
      step();
      exp_flags = 8'hFF << (k + 1);
      checks++; if (bus.flags !== exp_flags) begin failures++; $display("FAIL sweep_flags[%0d]: got %h expected %h", k, bus.flags, exp_flags); end
      checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL sweep_gnt[%0d]: got %b expected 0000", k, bus.gnt); end
      checks++; if (bus.busy !== (k < 7)) begin failures++; $display("FAIL sweep_busy[%0d]: got %b expected %b", k, bus.busy, (k < 7)); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL sweep_err[%0d]: got %b expected 0", k, bus.err); end
    end
    step();
    bus.req = '0;
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL sweep_resume_gnt: got %b expected 0010", bus.gnt); end
    checks++; if (bus.flags !== 8'h01) begin failures++; $display("FAIL sweep_resume_flags: got %h expected 01", bus.flags); end
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sweep_no_restart: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_sweep();
    set_cmd(2, 2'b10, 3'd7);
    step();
    bus.req = '0;
    step();
    checks++; if (bus.flags !== 8'h81) begin failures++; $display("FAIL rsweep_setup: got %h expected 81", bus.flags); end
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rsweep_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.flags !== 8'h80) begin failures++; $display("FAIL rsweep_flags: got %h expected 80", bus.flags); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rsweep_rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.flags !== 8'h00) begin failures++; $display("FAIL rsweep_rst_flags: got %h expected 00", bus.flags); end
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rsweep_after_busy: got %b expected 0", bus.busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req = '0; bus.req_sr = '0; bus.req_idx = '0; bus.clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_illegal();
    test_conflict();
    test_sweep();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
